// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//
// Eight-way round-robin arbiter that shares one resource among eight
// requesters. The winning requester's index is held in a register and
// expanded to a one-hot grant by a 3:8 decode, so exactly one requester
// owns the resource at any time. A programmable hold limit forcibly
// releases an owner that never finishes.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req[7:0]   level-sensitive request vector, bit i belongs to requester i
//   done       current owner has finished (only looked at during a grant)
//   gnt[7:0]   one-hot grant, all zero when no grant is active
//   gnt_idx    index of the current owner, zero when no grant is active
//   gnt_valid  a grant is active
//   timeout    one-cycle pulse (during the dead cycle) after a forced release
//
// Parameter:
//   MAX_HOLD   maximum grant length in cycles (0 disables the limit, 0..255)
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  // IDLE waits for a request, GRANT holds the resource for one owner,
  // GAP is the single dead cycle between two grants.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // The limit fires on the cycle where cnt reaches MAX_HOLD-1, i.e. on the
  // MAX_HOLD-th cycle of the grant. Truncation to 8 bits is harmless since
  // the legal range tops out at 255.
  localparam logic        HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0]  HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] ptr;
  logic [2:0] ptr_next;
  logic [2:0] idx;
  logic [2:0] idx_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       timeout_q;
  logic       timeout_next;

  logic       win_found;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       limit_hit;
  logic       release_now;

  // Rotating priority search. The loop walks offsets from the far end back
  // toward ptr so that the closest set bit (lowest offset) is the one left
  // standing. The 3-bit add wraps naturally, giving the modulo-8 order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (req[ptr + 3'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 3'(k);
      end
    end
  end

  // Release conditions while granting. A forced release only counts as a
  // timeout if neither done nor a withdrawn request would have ended the
  // grant on the same cycle.
  always_comb begin
    owner_req   = req[idx];
    limit_hit   = HOLD_EN && (cnt == HOLD_LAST);
    release_now = done || !owner_req || limit_hit;
  end

  // Next-state and next-register logic. Everything defaults to holding its
  // value, except the timeout flag, which is a one-cycle pulse and therefore
  // defaults to clear.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    idx_next     = idx;
    cnt_next     = cnt;
    timeout_next = 1'b0;

    unique case (state)
      IDLE, GAP: begin
        if (win_found) begin
          idx_next   = win_idx;
          cnt_next   = 8'd0;
          state_next = GRANT;
        end else begin
          state_next = IDLE;
        end
      end

      GRANT: begin
        cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        if (release_now) begin
          // The releasing owner drops to lowest priority for the next
          // round, which is what guarantees fairness.
          ptr_next     = idx + 3'd1;
          state_next   = GAP;
          timeout_next = limit_hit && !done && owner_req;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so the outputs
  // drop the moment reset is asserted, even in the middle of a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      idx       <= 3'd0;
      cnt       <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      idx       <= idx_next;
      cnt       <= cnt_next;
      timeout_q <= timeout_next;
    end
  end

  // Output decode from registers only, so there is no combinational path
  // from req to gnt. The index output is forced to zero outside a grant.
  always_comb begin
    gnt_valid = (state == GRANT);
    gnt_idx   = gnt_valid ? idx : 3'd0;
    gnt       = 8'd0;
    if (gnt_valid) begin
      unique case (idx)
        3'd0: gnt = 8'b0000_0001;
        3'd1: gnt = 8'b0000_0010;
        3'd2: gnt = 8'b0000_0100;
        3'd3: gnt = 8'b0000_1000;
        3'd4: gnt = 8'b0001_0000;
        3'd5: gnt = 8'b0010_0000;
        3'd6: gnt = 8'b0100_0000;
        3'd7: gnt = 8'b1000_0000;
        default: gnt = 8'd0;
      endcase
    end
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
//
// Self-checking bench for rr_arbiter8 (built with MAX_HOLD=4). Every driven
// cycle runs a behavioural reference model and pushes the expected outputs
// into a queue; a monitor pops and compares them shortly after each rising
// edge. Directed scenarios add constant expectations on top.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } expect_t;

  expect_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 idle, 1 grant, 2 gap.
  int   m_state;
  int   m_ptr;
  int   m_idx;
  int   m_cnt;
  logic m_to;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_ptr   = 0;
    m_idx   = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  // Advance the reference model by one clock and queue the outputs the DUT
  // should show after that edge.
  task automatic modelStep(input logic [7:0] r, input logic d);
    expect_t e;
    bit      found;
    bit      lim;
    int      j;
    if (m_state == 1) begin
      lim = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD - 1);
      if (d || !r[m_idx] || lim) begin
        m_to    = lim && !d && r[m_idx];
        m_ptr   = (m_idx + 1) % 8;
        m_state = 2;
      end else begin
        m_to = 1'b0;
        if (m_cnt < 255) m_cnt++;
      end
    end else begin
      m_to  = 1'b0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (!found && r[j]) begin
          found = 1;
          m_idx = j;
        end
      end
      if (found) begin
        m_cnt   = 0;
        m_state = 1;
      end else begin
        m_state = 0;
      end
    end
    e.valid = (m_state == 1);
    e.idx   = e.valid ? 3'(m_idx) : 3'd0;
    e.gnt   = e.valid ? (8'd1 << m_idx) : 8'd0;
    e.to    = m_to;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge and record expectations.
  task automatic applyStimulus(input logic [7:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    modelStep(r, d);
  endtask

  task automatic waitSample();
    @(posedge clk);
    #2;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic doReset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_idx", gnt_idx, 0);
    checkOutput("rst_valid", gnt_valid, 0);
    checkOutput("rst_timeout", timeout, 0);
    exp_q.delete();
    modelReset();
    req  = 8'd0;
    done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: compare queued expectations just after each edge.
  always @(posedge clk) begin
    expect_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_gnt", gnt, e.gnt);
      checkOutput("sb_idx", gnt_idx, e.idx);
      checkOutput("sb_valid", gnt_valid, e.valid);
      checkOutput("sb_timeout", timeout, e.to);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq[$];
    int exp_v1[6];
    int exp_t1[6];
    int exp_v2[5];

    reset = 1'b1;
    req   = 8'd0;
    done  = 1'b0;
    modelReset();
    #1;
    checkOutput("init_gnt", gnt, 0);
    checkOutput("init_valid", gnt_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single requester, then done -> one dead cycle -> idle.
    applyStimulus(8'b0010_0000, 1'b0);
    waitSample();
    checkOutput("single_gnt", gnt, 8'b0010_0000);
    checkOutput("single_idx", gnt_idx, 5);
    applyStimulus(8'b0010_0000, 1'b1);
    waitSample();
    checkOutput("single_gap", gnt_valid, 0);
    applyStimulus(8'd0, 1'b0);
    applyStimulus(8'd0, 1'b0);

    // Pointer wrap: release idx 6 so ptr=7, then req 0x03 picks 0 before 1.
    applyStimulus(8'b0100_0000, 1'b0);
    applyStimulus(8'b0100_0000, 1'b1);
    applyStimulus(8'b0000_0011, 1'b0);
    waitSample();
    checkOutput("wrap_first", gnt_idx, 0);
    applyStimulus(8'b0000_0011, 1'b1);
    applyStimulus(8'b0000_0011, 1'b0);
    waitSample();
    checkOutput("wrap_second", gnt_idx, 1);
    applyStimulus(8'b0000_0011, 1'b1);
    applyStimulus(8'd0, 1'b0);

    // Reset in the middle of a grant to idx 3, then restart from index 0.
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h08, 1'b0);
    doReset();
    applyStimulus(8'h08, 1'b0);
    waitSample();
    checkOutput("post_rst_gnt", gnt, 8'h08);
    applyStimulus(8'h08, 1'b1);
    applyStimulus(8'd0, 1'b0);

    // Full round-robin sweep from ptr=0 with done on every first cycle.
    doReset();
    for (int c = 0; c < 18; c++) begin
      applyStimulus(8'hFF, 1'b1);
      waitSample();
      if (gnt_valid) seq.push_back(int'(gnt_idx));
    end
    checkOutput("rr_count", seq.size(), 9);
    for (int i = 0; i < seq.size() && i < 9; i++)
      checkOutput($sformatf("rr_idx%0d", i), seq[i], i % 8);
    applyStimulus(8'd0, 1'b1);

    // Forced release after MAX_HOLD cycles, then regrant to the same owner.
    exp_v1 = '{1, 1, 1, 1, 0, 1};
    exp_t1 = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h10, 1'b0);
      waitSample();
      checkOutput($sformatf("hold_valid%0d", i), gnt_valid, exp_v1[i]);
      checkOutput($sformatf("hold_to%0d", i), timeout, exp_t1[i]);
    end
    checkOutput("hold_regrant", gnt_idx, 4);

    // Same grant length but done arrives on the last cycle: no timeout.
    exp_v2 = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 4) ? 8'd0 : 8'h10, (i == 3));
      waitSample();
      checkOutput($sformatf("done_valid%0d", i), gnt_valid, exp_v2[i]);
      checkOutput($sformatf("done_to%0d", i), timeout, 0);
    end

    // Withdrawal: owner 2 drops its request while 5 waits.
    applyStimulus(8'b0000_0100, 1'b0);
    waitSample();
    checkOutput("wd_owner", gnt_idx, 2);
    applyStimulus(8'b0010_0100, 1'b0);
    applyStimulus(8'b0010_0000, 1'b0);
    waitSample();
    checkOutput("wd_gap_valid", gnt_valid, 0);
    checkOutput("wd_gap_to", timeout, 0);
    applyStimulus(8'b0010_0000, 1'b0);
    waitSample();
    checkOutput("wd_next", gnt_idx, 5);
    checkOutput("wd_next_to", timeout, 0);
    applyStimulus(8'b0010_0000, 1'b1);
    applyStimulus(8'd0, 1'b0);

    // Random traffic checked by the scoreboard alone.
    for (int i = 0; i < 60; i++)
      applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0));
    applyStimulus(8'd0, 1'b1);
    applyStimulus(8'd0, 1'b0);

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares a single resource among eight requesters. The winner's 3-bit index is held in a register and expanded to a one-hot grant by a 3:8 decode stage, so exactly one requester owns the resource at a time. A hold limit forces release from a requester that never finishes. It sits in front of any shared datapath port, such as a memory or bus, that the eight clients must take turns on.

## Interface
- MAX_HOLD, default 15: maximum grant length in cycles before forced release. Value 0 disables the limit. Legal range 0..255.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  8  request vector; bit i is requester i, level-sensitive
- done  in  1  current owner has finished; valid only while gnt_valid=1
- gnt  out  8  one-hot grant; 8'b0 when gnt_valid=0
- gnt_idx  out  3  index of current owner; 0 when gnt_valid=0
- gnt_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse marking a forced release

## Operation
- State registers:
  - FSM state: IDLE, GRANT, GAP.
  - ptr[2:0]: highest-priority index for the next arbitration.
  - idx[2:0]: current winner.
  - cnt[7:0]: hold counter.
  - timeout flag.
- Arbitration is performed in IDLE and in GAP:
  - Scan req starting at ptr and moving upward, modulo 8.
  - The first set bit wins.
  - Example: ptr=6 gives the order 6,7,0,1,…,5.
- IDLE:
  - If req is nonzero: idx is set to the winner, cnt is set to 0, next state is GRANT.
  - Otherwise stay in IDLE.
  - done is ignored in IDLE.
- GRANT:
  - gnt_valid=1, gnt_idx=idx, gnt=decode(idx).
  - cnt increments by 1 each cycle and saturates at 255.
  - The grant ends when any of the following occurs:
    - done=1
    - req[idx]=0 (the requester withdraws)
    - MAX_HOLD≠0 and cnt==MAX_HOLD-1, i.e. the grant has lasted MAX_HOLD cycles
  - On release: ptr is set to idx+1 (wraps 7→0) and next state is GAP.
  - timeout is set to 1 only if the limit was the sole cause. If done or a request drop happens in the same cycle, the release counts as normal and timeout stays 0.
- GAP:
  - Exactly one cycle with gnt=0 and gnt_valid=0.
  - Performs arbitration like IDLE: if any request is pending, go to GRANT with the new winner; otherwise go to IDLE.
  - timeout, if set on entry, is high during this cycle and cleared at the next edge.
- Fairness: a requester that keeps req high is granted within 7 grants.
- The releasing requester can win again only if no other request is pending.
- Output decode: gnt must equal 1<<gnt_idx when gnt_valid=1, and be 8'b0 otherwise. Outputs are driven purely from registers, with no path from req to gnt in the same cycle.
- Reset, asynchronous and at any time including mid-grant:
  - state=IDLE, ptr=0, idx=0, cnt=0, timeout=0.
  - All outputs are 0 immediately.
  - After deassertion, arbitration restarts from index 0.

## Timing
- Grant latency: if req is first sampled nonzero at edge k while in IDLE, gnt_valid is 1 after edge k.
- Release: done sampled at edge k causes gnt_valid to be 0 after edge k, for exactly one cycle (GAP).
- Back-to-back grants: a new grant is valid after edge k+1. Minimum spacing between grants is 1 dead cycle.
- Minimum grant length is 1 cycle, e.g. done already high on the first GRANT cycle.
- Forced release:
  - A grant starting after edge k is dropped after edge k+MAX_HOLD.
  - timeout is high in the following cycle only.
- req changes during GAP are sampled by GAP's arbitration at the GAP→next edge.

## Test plan
- Reset values: assert reset mid-grant (idx=3, cnt=5) → gnt=0, gnt_idx=0, gnt_valid=0, timeout=0 without waiting for a clock edge. After release, req=8'h08 → gnt=8'h08 one edge later.
- Single requester: req=8'b0010_0000 from IDLE → after 1 edge gnt=8'b0010_0000, gnt_idx=5. Pulse done → one cycle of gnt=0, then IDLE.
- Round-robin wrap: req=8'hFF held, done pulsed on each grant's first cycle → gnt_idx sequence 0,1,2,3,4,5,6,7,0, each separated by one GAP cycle.
- Pointer wrap / skip: grant idx 6 released, so ptr=7; then req=8'b0000_0011 → winner is idx 0, not 1. Next grant with req unchanged → idx 1.
- Timeout: MAX_HOLD=4, req=8'h10 held, done=0 → gnt_valid high exactly 4 cycles, then a GAP with timeout=1 for 1 cycle, then a regrant to idx 4. Repeat with done=1 on cycle 4 → timeout stays 0.
- Withdrawal: owner idx 2 drops req[2] mid-grant while req[5]=1 → release, one GAP cycle, then gnt_idx=5 with timeout=0.
